// File: rtl/tone_clk_divider.sv
// -----------------------------------------------------------------------------
// tone_clk_divider
//
// Runtime-programmable square-wave divider for the audio path. The tone output
// toggles every `half` enabled clock cycles. New half-periods arrive from the
// note sequencer through a ready/valid style load. They are held as pending
// and take effect only at a half-period boundary, so the output never glitches.
// A half-period of 0 mutes the output.
//
// Ports:
//   clk        in   system clock, rising edge
//   rst        in   asynchronous active-high reset
//   en         in   run enable; low freezes the counter and holds tone_out
//   div_load   in   load strobe, taken only while div_ready is high
//   div_value  in   requested half-period in cycles (0 = mute)
//   div_ready  out  high when no load is pending
//   tone_out   out  registered square wave
//   tick       out  registered one-cycle pulse on every tone_out toggle
// -----------------------------------------------------------------------------
module tone_clk_divider #(
  parameter int          WIDTH        = 22,
  parameter int unsigned DEFAULT_HALF = 1493
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             div_load,
  input  logic [WIDTH-1:0] div_value,
  output logic             div_ready,
  output logic             tone_out,
  output logic             tick
);

  logic [WIDTH-1:0] r_cnt;
  logic [WIDTH-1:0] r_half;
  logic [WIDTH-1:0] r_pend;
  logic             r_pend_v;
  logic             r_tone;
  logic             r_tick;

  logic [WIDTH-1:0] w_half_m1;
  logic             w_mute;
  logic             w_boundary;
  logic             w_accept;

  // half-1 is only meaningful when half != 0; the mute branch never uses it.
  assign w_half_m1  = r_half - {{(WIDTH-1){1'b0}}, 1'b1};
  assign w_mute     = (r_half == '0);
  assign w_boundary = !w_mute && en && (r_cnt == w_half_m1);
  // A load that arrives while a value is already pending is ignored.
  assign w_accept   = div_load && !r_pend_v;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt    <= '0;
      r_half   <= WIDTH'(DEFAULT_HALF);
      r_pend   <= '0;
      r_pend_v <= 1'b0;
      r_tone   <= 1'b0;
      r_tick   <= 1'b0;
    end else begin
      r_tick <= 1'b0;

      if (w_mute) begin
        r_cnt  <= '0;
        r_tone <= 1'b0;
        // While muted, a pending value is taken on the very next cycle,
        // independent of en.
        if (r_pend_v) begin
          r_half   <= r_pend;
          r_pend_v <= 1'b0;
        end
      end else if (en) begin
        if (w_boundary) begin
          r_cnt <= '0;
          if (r_pend_v) begin
            r_half   <= r_pend;
            r_pend_v <= 1'b0;
            if (r_pend == '0) begin
              // Entering mute: force low, strobe only if the level changes.
              r_tone <= 1'b0;
              r_tick <= r_tone;
            end else begin
              r_tone <= ~r_tone;
              r_tick <= 1'b1;
            end
          end else begin
            r_tone <= ~r_tone;
            r_tick <= 1'b1;
          end
        end else begin
          r_cnt <= r_cnt + {{(WIDTH-1){1'b0}}, 1'b1};
        end
      end

      // Capture uses the pre-edge pend_v, so a value taken in the same cycle
      // as a boundary waits for the following boundary.
      if (w_accept) begin
        r_pend   <= div_value;
        r_pend_v <= 1'b1;
      end
    end
  end

  assign div_ready = !r_pend_v;
  assign tone_out  = r_tone;
  assign tick      = r_tick;

endmodule

// File: tb/tb_tone_clk_divider.sv
module tb_tone_clk_divider;

  localparam int WIDTH = 8;
  localparam int DEF_H = 3;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             en = 1'b0;
  logic             div_load = 1'b0;
  logic [WIDTH-1:0] div_value = '0;
  logic             div_ready;
  logic             tone_out;
  logic             tick;

  tone_clk_divider #(.WIDTH(WIDTH), .DEFAULT_HALF(DEF_H)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .div_load  (div_load),
    .div_value (div_value),
    .div_ready (div_ready),
    .tone_out  (tone_out),
    .tick      (tick)
  );

  always #5 clk = ~clk;

  // Number of rising edges seen so far; read at the falling edge it equals the
  // index of the edge that just happened.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int   c;
    logic tone;
  } tick_t;

  tick_t exp_q[$];
  int    n_vec = 0;
  int    n_err = 0;

  task automatic check(input string name, input int act, input int req);
    n_vec++;
    if (act != req) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (edge %0d)", name, act, req, cyc);
    end
  endtask

  function automatic void exp_tick(input int c, input logic t);
    tick_t e;
    e.c    = c;
    e.tone = t;
    exp_q.push_back(e);
  endfunction

  // Monitor: every tick the DUT presents is matched against the next
  // expected toggle (edge index and new tone level).
  always @(negedge clk) begin
    if (tick) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_tick: tick at edge %0d, tone %0d, none expected", cyc, tone_out);
      end else begin
        tick_t e;
        e = exp_q.pop_front();
        n_vec++;
        if (e.c != cyc || e.tone != tone_out) begin
          n_err++;
          $display("FAIL tick_event: got edge %0d tone %0d, expected edge %0d tone %0d",
                   cyc, tone_out, e.c, e.tone);
        end
      end
    end
  end

  task automatic at(input int e);
    while (cyc < e) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached at edge %0d", cyc);
    $fatal(1, "watchdog");
  end

  int b;
  int b2;

  initial begin
    repeat (2) @(negedge clk);
    check("reset_tone", tone_out, 0);
    check("reset_tick", tick, 0);
    check("reset_ready", div_ready, 1);

    // 1: default half-period 3 right after reset release
    rst = 1'b0;
    en  = 1'b1;
    b   = cyc;
    exp_tick(b + 3, 1'b1);
    exp_tick(b + 6, 1'b0);
    exp_tick(b + 9, 1'b1);
    at(b + 2);
    check("pre_first_toggle_tone", tone_out, 0);

    // 2: load 5 at cnt=1, current half completes first
    at(b + 10);
    div_load = 1'b1; div_value = 8'd5;
    exp_tick(b + 12, 1'b0);
    exp_tick(b + 17, 1'b1);
    exp_tick(b + 22, 1'b0);
    exp_tick(b + 27, 1'b1);
    at(b + 11);
    div_load = 1'b0;
    check("ready_low_after_accept", div_ready, 0);
    at(b + 12);
    check("ready_high_after_apply", div_ready, 1);

    // 3: load 0 while tone=1 -> forced low with one tick, then mute
    at(b + 27);
    div_load = 1'b1; div_value = 8'd0;
    exp_tick(b + 32, 1'b0);
    at(b + 28);
    div_load = 1'b0;
    at(b + 40);
    check("mute_tone_low", tone_out, 0);
    // load 4 from mute: captured next edge, applied the edge after
    div_load = 1'b1; div_value = 8'd4;
    exp_tick(b + 46, 1'b1);
    exp_tick(b + 50, 1'b0);
    at(b + 41);
    div_load = 1'b0;
    check("mute_ready_low", div_ready, 0);
    at(b + 42);
    check("mute_ready_high", div_ready, 1);

    // 4: second load while pending is ignored (9 applied, 7 never)
    at(b + 50);
    div_load = 1'b1; div_value = 8'd9;
    exp_tick(b + 54, 1'b1);
    exp_tick(b + 63, 1'b0);
    exp_tick(b + 72, 1'b1);
    at(b + 51);
    div_value = 8'd7;
    at(b + 52);
    div_load = 1'b0;
    check("ready_low_while_pending", div_ready, 0);

    // 5: pause 10 cycles at cnt=1, with a load of 2 accepted while paused
    at(b + 73);
    en = 1'b0;
    at(b + 75);
    div_load = 1'b1; div_value = 8'd2;
    at(b + 76);
    div_load = 1'b0;
    at(b + 80);
    check("pause_tone_hold", tone_out, 1);
    check("pause_ready_low", div_ready, 0);
    at(b + 83);
    en = 1'b1;
    exp_tick(b + 91, 1'b0);
    exp_tick(b + 93, 1'b1);
    exp_tick(b + 95, 1'b0);
    exp_tick(b + 97, 1'b1);
    at(b + 90);
    check("resume_before_toggle", tone_out, 1);

    // 6: async reset mid-operation with a pending load
    at(b + 97);
    div_load = 1'b1; div_value = 8'd6;
    at(b + 98);
    div_load = 1'b0;
    check("pre_reset_ready", div_ready, 0);
    check("pre_reset_tone", tone_out, 1);
    #2;
    rst = 1'b1;
    #1;
    check("async_reset_tone", tone_out, 0);
    check("async_reset_ready", div_ready, 1);
    check("async_reset_tick", tick, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    b2  = cyc;
    exp_tick(b2 + 3, 1'b1);
    exp_tick(b2 + 6, 1'b0);
    at(b2 + 8);
    check("post_reset_ready", div_ready, 1);

    while (exp_q.size() > 0) begin
      tick_t e;
      e = exp_q.pop_front();
      n_vec++;
      n_err++;
      $display("FAIL missing_tick: got none, expected edge %0d tone %0d", e.c, e.tone);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
